// File: rtl/wb_regfile.sv
// Write-back stage: selects the commit value from the MEM/WB payload, owns the
// 32-entry architectural register file and serves two write-first read ports.
module wb_regfile #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     MemRdDataIn,
   input  logic [DATA_W-1:0]     MemALUresultIn,
   input  logic [DM_ADDRESS-1:0] PCin,
   input  logic [DATA_W-1:0]     immIn,
   input  logic                  RegWrtEnIn,
   input  logic [2:0]            RegWrtSrcIn,
   input  logic [4:0]            RegDstIn,
   input  logic [4:0]            RdAddr1,
   input  logic [4:0]            RdAddr2,
   output logic [DATA_W-1:0]     RdData1,
   output logic [DATA_W-1:0]     RdData2,
   output logic [DATA_W-1:0]     WbData,
   output logic                  WbValid,
   output logic [31:0]           RetireCnt
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [31:0]       retire_cnt;
   logic [DATA_W-1:0] pc_ext;
   logic              src_ok;

   assign pc_ext = {{(DATA_W-DM_ADDRESS){1'b0}}, PCin};
   assign src_ok = (RegWrtSrcIn <= 3'd4);

   always_comb begin
      WbData = '0;
      case (RegWrtSrcIn)
         3'd0:    WbData = MemALUresultIn;
         3'd1:    WbData = MemRdDataIn;
         3'd2:    WbData = pc_ext + DATA_W'(4);
         3'd3:    WbData = immIn;
         3'd4:    WbData = pc_ext + immIn;
         default: WbData = '0;
      endcase
   end

   // Reset also kills the bypass so reads see zero while rst is high.
   assign WbValid = !rst && RegWrtEnIn && (RegDstIn != 5'd0) && src_ok;

   function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
      if (addr == 5'd0)
         return '0;
      else if (WbValid && (addr == RegDstIn))
         return WbData;
      else
         return regs[addr];
   endfunction

   assign RdData1   = read_port(RdAddr1);
   assign RdData2   = read_port(RdAddr2);
   assign RetireCnt = retire_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         retire_cnt <= '0;
      end else if (WbValid) begin
         regs[RegDstIn] <= WbData;
         retire_cnt     <= retire_cnt + 32'd1;
      end
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register. Takes the registered MEM/WB payload (mem read data, ALU result, PC, immediate, write enable, write-source select, destination register).
- Selects the write-back value and commits it to a 32x32 architectural register file.
- Serves two combinational read ports to the decode stage, with write-first bypass.
- Exports the selected write-back value for EX-stage forwarding, plus a retired-write counter.

Parameters:
- DM_ADDRESS, 9: PC width in bits.
- DATA_W, 32: data and register width.
- NUM_REGS, 32: register count. Index width is 5 bits, fixed.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- MemRdDataIn  input  DATA_W  load data from MEM/WB; already sign/zero-extended.
- MemALUresultIn  input  DATA_W  ALU result from MEM/WB.
- PCin  input  DM_ADDRESS  PC of the instruction in WB.
- immIn  input  DATA_W  immediate from MEM/WB.
- RegWrtEnIn  input  1  write-back enable.
- RegWrtSrcIn  input  3  write-back source select.
- RegDstIn  input  5  destination register index.
- RdAddr1  input  5  read port 1 index.
- RdAddr2  input  5  read port 2 index.
- RdData1  output  DATA_W  read port 1 data.
- RdData2  output  DATA_W  read port 2 data.
- WbData  output  DATA_W  selected write-back value, for forwarding.
- WbValid  output  1  high when a register is actually written this cycle.
- RetireCnt  output  32  count of committed register writes.

Behaviour:
- Source select on RegWrtSrcIn (combinational), producing WbData. PC is zero-extended to DATA_W.
  - 000: MemALUresultIn
  - 001: MemRdDataIn
  - 010: PCin + 4 (JAL/JALR link)
  - 011: immIn (LUI)
  - 100: PCin + immIn (AUIPC), truncated to DATA_W
  - 101-111: reserved. WbData = 0 and WbValid = 0. No write occurs even if RegWrtEnIn = 1.
- WbValid = RegWrtEnIn AND (RegDstIn != 0) AND RegWrtSrcIn is not reserved. Combinational.
- Write: on posedge clk with WbValid = 1, regs[RegDstIn] <= WbData.
- x0: always reads 0. A write to x0 is dropped and does not count.
- Read (combinational):
  - If RdAddrN == 0, RdDataN = 0.
  - Else if WbValid and RdAddrN == RegDstIn, RdDataN = WbData (write-first bypass, same cycle).
  - Else RdDataN = regs[RdAddrN].
- Both ports may address the same register, and may both hit the bypass simultaneously.
- RetireCnt increments by 1 on each posedge with WbValid = 1. It wraps from 0xFFFFFFFF to 0 with no flag.
- Latency:
  - WbData and WbValid: 0 cycles from inputs.
  - Register contents visible via the array 1 cycle after the write edge, and via bypass in the same cycle.
- Reset (asynchronous, immediate on rst rise, independent of clk):
  - All regs = 0, RetireCnt = 0.
  - RdData1 = RdData2 = 0 for all addresses, unless a bypass hit applies.
- While rst = 1:
  - No writes commit and RetireCnt holds at 0.
  - WbValid is forced to 0, so the bypass is disabled and RdData reads 0.
- Reset deasserted mid-stream: the first posedge after deassertion commits normally.
- Inputs are sampled only at posedge. No internal pipelining of the inputs; upstream holds all registering.

Test Plan:
- Reset sequence: write x5=0x1234, then assert rst asynchronously between edges -> RdData1(x5)=0 immediately, RetireCnt=0. Deassert rst -> x5 still reads 0.
- Source mux: PCin=0x010 and immIn=0x00001000, step RegWrtSrcIn 000..100 into x1..x5 with ALU=0xA, Mem=0xB:
  - x1=0xA, x2=0xB, x3=0x14, x4=0x1000, x5=0x1010.
  - RetireCnt=5.
- x0 and reserved sources:
  - RegDstIn=0, RegWrtEnIn=1, ALU=0xFF -> RdData(x0)=0, RetireCnt unchanged.
  - RegWrtSrcIn=110 into x7 -> x7 unchanged, WbValid=0.
- Bypass: x9=0x1 stored, then same cycle WB writes x9=0x2 with RdAddr1=RdAddr2=9 -> both ports read 0x2 before the edge, and 0x2 from the array after the edge.
- Enable gating: RegWrtEnIn=0 with RegDstIn=3, ALU=0x77 -> x3 unchanged, no bypass, WbValid=0, RetireCnt unchanged.
- Counter wrap: force RetireCnt to 0xFFFFFFFF (or run sufficient writes), then one valid write -> RetireCnt=0.
